// File: rtl/cond_logic_wb.sv
// Writeback conditional-execution unit: holds NZCV, decides commit/redirect,
// and squashes the wrong-path instructions behind a taken branch.
module cond_logic_wb #(
  parameter int SQUASH_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       CondW,
  input  logic [3:0]       ALUFlagsW,
  input  logic             FlagsWriteW,
  input  logic             BranchW,
  input  logic             RegWriteW,
  output logic             PCSrc,
  output logic             CondExW,
  output logic             RegWriteEnW,
  output logic [3:0]       Flags,
  output logic             SquashActive,
  output logic [CNT_W-1:0] BranchCount
);

  localparam int SQW = $clog2(SQUASH_CYCLES + 1);
  localparam logic [SQW-1:0] SQ_LOAD = SQW'(SQUASH_CYCLES);
  localparam logic [SQW-1:0] SQ_LAST = SQW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_t;

  state_t         state;
  logic [SQW-1:0] cnt;
  logic           flag_n, flag_z, flag_c, flag_v;
  logic           pass;

  assign {flag_n, flag_z, flag_c, flag_v} = Flags;

  // Condition is checked against the registered flags only; no bypass from ALUFlagsW.
  always_comb begin
    pass = 1'b1;
    case (CondW)
      4'b0000: pass = flag_z;
      4'b0001: pass = !flag_z;
      4'b0010: pass = flag_c;
      4'b0011: pass = !flag_c;
      4'b0100: pass = flag_n;
      4'b0101: pass = !flag_n;
      4'b0110: pass = flag_v;
      4'b0111: pass = !flag_v;
      4'b1000: pass = flag_c && !flag_z;
      4'b1001: pass = !flag_c || flag_z;
      4'b1010: pass = (flag_n == flag_v);
      4'b1011: pass = (flag_n != flag_v);
      4'b1100: pass = !flag_z && (flag_n == flag_v);
      4'b1101: pass = flag_z || (flag_n != flag_v);
      default: pass = 1'b1;
    endcase
  end

  // reset appears here so nothing commits while the unit is held in reset.
  assign CondExW      = reset && pass && (state == RUN);
  assign PCSrc        = BranchW && CondExW;
  assign RegWriteEnW  = RegWriteW && CondExW;
  assign SquashActive = (state == SQUASH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      cnt         <= '0;
      Flags       <= 4'b0000;
      BranchCount <= '0;
    end else begin
      if (FlagsWriteW && CondExW) begin
        Flags <= ALUFlagsW;
      end
      if (PCSrc && (BranchCount != CNT_MAX)) begin
        BranchCount <= BranchCount + CNT_W'(1);
      end
      case (state)
        RUN: begin
          if (PCSrc) begin
            state <= SQUASH;
            cnt   <= SQ_LOAD;
          end
        end
        SQUASH: begin
          // Branches seen here are wrong-path, so they never restart the window.
          if (cnt == SQ_LAST) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - SQW'(1);
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cond_logic_wb.sv
// Bench for cond_logic_wb: one instance at default width, one with a 2-bit
// counter, both driven by the same W-stage stream and checked against a model.
module tb_cond_logic_wb;

  localparam int SQ  = 4;
  localparam int EW  = 26;
  localparam int BIG = 65535;
  localparam int SML = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  cond = 4'b1110;
  logic [3:0]  alu = 4'b0000;
  logic        fw = 1'b0;
  logic        br = 1'b0;
  logic        rw = 1'b0;

  logic        pc_a, cex_a, rwe_a, sq_a;
  logic [3:0]  flags_a;
  logic [15:0] bc_a;
  logic        pc_b, cex_b, rwe_b, sq_b;
  logic [3:0]  flags_b;
  logic [1:0]  bc_b;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_cycle  = 0;

  logic [3:0] m_flags = 4'b0000;
  int m_sq  = 0;
  int m_big = 0;
  int m_sml = 0;

  always #5 clk = ~clk;

  cond_logic_wb #(.SQUASH_CYCLES(SQ), .CNT_W(16)) dut (
    .clk(clk), .reset(rst), .CondW(cond), .ALUFlagsW(alu), .FlagsWriteW(fw),
    .BranchW(br), .RegWriteW(rw), .PCSrc(pc_a), .CondExW(cex_a),
    .RegWriteEnW(rwe_a), .Flags(flags_a), .SquashActive(sq_a), .BranchCount(bc_a)
  );

  cond_logic_wb #(.SQUASH_CYCLES(SQ), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(rst), .CondW(cond), .ALUFlagsW(alu), .FlagsWriteW(fw),
    .BranchW(br), .RegWriteW(rw), .PCSrc(pc_b), .CondExW(cex_b),
    .RegWriteEnW(rwe_b), .Flags(flags_b), .SquashActive(sq_b), .BranchCount(bc_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, n_cycle, act, exp);
    end
  endtask

  // ARM conditions come in pairs: odd codes are the negation of the even one.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] fl);
    logic n, z, cf, v, base;
    {n, z, cf, v} = fl;
    if (c[3:1] == 3'b111) return 1'b1;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf & ~z;
      3'd5:    base = (n == v);
      default: base = ~z & (n == v);
    endcase
    return c[0] ? ~base : base;
  endfunction

  task automatic drive(input logic r, input logic [3:0] c, input logic [3:0] a,
                       input logic f, input logic b, input logic w);
    logic e_pc, e_cex, e_rwe, e_sq;
    logic [3:0] e_fl;
    logic [15:0] e_big;
    logic [1:0] e_sml;
    @(posedge clk);
    #1;
    rst = r; cond = c; alu = a; fw = f; br = b; rw = w;
    if (!r) begin
      m_flags = 4'b0000; m_sq = 0; m_big = 0; m_sml = 0;
      e_pc = 1'b0; e_cex = 1'b0; e_rwe = 1'b0; e_sq = 1'b0;
      e_fl = 4'b0000; e_big = '0; e_sml = '0;
    end else begin
      e_sq  = (m_sq > 0);
      e_cex = cond_ok(c, m_flags) && !e_sq;
      e_pc  = b && e_cex;
      e_rwe = w && e_cex;
      e_fl  = m_flags;
      e_big = 16'(m_big);
      e_sml = 2'(m_sml);
      if (e_cex && f) m_flags = a;
      if (e_sq) m_sq = m_sq - 1;
      else if (e_pc) m_sq = SQ;
      if (e_pc) begin
        if (m_big < BIG) m_big = m_big + 1;
        if (m_sml < SML) m_sml = m_sml + 1;
      end
    end
    exp_q.push_back({e_pc, e_cex, e_rwe, e_fl, e_sq, e_big, e_sml});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic set_flags(input logic [3:0] fl);
    drive(1'b1, 4'b1110, fl, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle the DUT presents a W-stage decision, compare it.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cycle++;
      chk("pcsrc",      32'(pc_a),    32'(e[25]));
      chk("condex",     32'(cex_a),   32'(e[24]));
      chk("regwriteen", 32'(rwe_a),   32'(e[23]));
      chk("flags",      32'(flags_a), 32'(e[22:19]));
      chk("squash",     32'(sq_a),    32'(e[18]));
      chk("bcount",     32'(bc_a),    32'(e[17:2]));
      chk("sat_pcsrc",  32'(pc_b),    32'(e[25]));
      chk("sat_squash", 32'(sq_b),    32'(e[18]));
      chk("sat_bcount", 32'(bc_b),    32'(e[1:0]));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_sat [5] = '{1, 2, 3, 3, 3};
    logic [3:0] sflags [6] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0010, 4'b0110};
    logic [3:0] sconds [6] = '{4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1000, 4'b1000};
    logic       spass  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset held with an AL branch in W, then released.
    for (int i = 0; i < 3; i++) drive(1'b0, 4'b1110, 4'b0000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("reset_pcsrc", 32'(pc_a), 32'd0);
    chk("reset_bcount", 32'(bc_a), 32'd0);
    drive(1'b1, 4'b1110, 4'b0000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("release_pcsrc", 32'(pc_a), 32'd1);
    idle(SQ + 1);

    // Flag path: EQ sees the new Z one cycle later, NE does not pass.
    set_flags(4'b0100);
    drive(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("eq_regwriteen", 32'(rwe_a), 32'd1);
    set_flags(4'b0100);
    drive(1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("ne_condex", 32'(cex_a), 32'd0);

    // Squash window with a second branch arriving inside it.
    drive(1'b1, 4'b1110, 4'b0000, 1'b0, 1'b1, 1'b1);
    idle(1);
    drive(1'b1, 4'b1110, 4'b0000, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("inner_branch_pcsrc", 32'(pc_a), 32'd0);
    idle(2);
    idle(1);
    @(negedge clk);
    chk("post_squash_regwriteen", 32'(rwe_a), 32'd1);

    // Signed / unsigned compares.
    for (int i = 0; i < 6; i++) begin
      set_flags(sflags[i]);
      drive(1'b1, sconds[i], 4'b0000, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk("cmp_condex", 32'(cex_a), 32'(spass[i]));
    end

    // Flag-setting branch is judged on the old flags, then updates them.
    set_flags(4'b0100);
    drive(1'b1, 4'b0000, 4'b0010, 1'b1, 1'b1, 1'b0);
    idle(SQ + 1);

    // Reset in the middle of a squash window.
    drive(1'b1, 4'b1110, 4'b0000, 1'b0, 1'b1, 1'b0);
    idle(2);
    drive(1'b0, 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("after_reset_squash", 32'(sq_a), 32'd0);
    chk("after_reset_commit", 32'(rwe_a), 32'd1);

    // Saturation of the 2-bit counter from a fresh reset.
    drive(1'b0, 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b1110, 4'b0000, 1'b0, 1'b1, 1'b0);
      idle(1);
      @(negedge clk);
      chk("sat_sequence", 32'(bc_b), 32'(exp_sat[i]));
      idle(SQ);
    end
    chk("big_not_saturated", 32'(bc_a), 32'd5);

    // Randomised stream.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 63) != 0), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
